fifo_rr_controller: RTL and testbench

Round-robin controller that shares one `FIFObuffer` (4-bit, 8-deep) between `NREQ` producers and one consumer. It owns every FIFO control pin (`EN`, `WR`, `RD`, `Rst`, `dataIn`), keeps its own occupancy count, and sequences writes and reads so that `WR` and `RD` are never asserted in the same cycle. It also returns FIFO data through a valid/ready output stage and cross-checks the FIFO's `FULL`/`EMPTY` flags against its own count.

---
 rtl/fifo_ctrl_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/fifo_rr_controller.sv | 142 ++++++++++++++
 tb/tb_fifo_rr_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared constants for the round-robin FIFO controller: state encoding,
// default data width/depth and a constant log2 helper.
package fifo_ctrl_pkg;

  localparam int unsigned DEF_DW    = 4;
  localparam int unsigned DEF_DEPTH = 8;

  localparam logic [0:0] S_FLUSH = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  // Ceiling log2, usable in parameter and port-width expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after
// `last`, returning both a one-hot grant and its encoded index.
module rr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  int cand;

  // Scan farthest-to-nearest so the nearest requester after `last` wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = last;
    cand    = 0;
    for (int i = int'(NREQ); i > 0; i--) begin
      cand = (int'(last) + i) % int'(NREQ);
      if (req[IW'(cand)]) begin
        gnt             = '0;
        gnt[IW'(cand)]  = 1'b1;
        gnt_idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_controller.sv
// Shares one FIFO between NREQ producers and a single consumer; writes and
// reads never overlap, popped data leaves through a valid/ready register.
module fifo_rr_controller
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Flush,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  output logic [DW-1:0]     out_data,
  input  logic              out_ready,
  output logic              fifo_EN,
  output logic              fifo_WR,
  output logic              fifo_RD,
  output logic              fifo_Rst,
  output logic [DW-1:0]     fifo_dataIn,
  input  logic [DW-1:0]     fifo_dataOut,
  input  logic              fifo_FULL,
  input  logic              fifo_EMPTY,
  output logic              busy,
  output logic              err
);

  localparam int unsigned IW = clog2(NREQ);
  localparam int unsigned CW = clog2(DEPTH) + 1;

  logic [0:0]      state, state_nxt;
  logic [CW-1:0]   count;
  logic [IW-1:0]   last, gnt_idx;
  logic [NREQ-1:0] gnt;
  logic [DW-1:0]   wr_data;
  logic            phase, rd_inflight, first_run;
  logic            wr_ok, rd_ok, do_wr, do_rd;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .last    (last),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign wr_ok = (|req_valid) && (count < CW'(DEPTH)) && !Flush;
  assign rd_ok = (count != '0) && !rd_inflight && !out_valid && !Flush;
  assign busy  = (count != '0) || rd_inflight || out_valid;

  always_comb begin
    wr_data = '0;
    for (int i = 0; i < int'(NREQ); i++)
      if (gnt[i]) wr_data = req_data[i*DW +: DW];
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= S_FLUSH;
    else        state <= state_nxt;
  end

  // Next state and FIFO controls; reset forces every control to its idle value.
  always_comb begin
    state_nxt   = state;
    fifo_Rst    = 1'b1;
    fifo_EN     = 1'b0;
    fifo_WR     = 1'b0;
    fifo_RD     = 1'b0;
    fifo_dataIn = '0;
    req_ready   = '0;
    do_wr       = 1'b0;
    do_rd       = 1'b0;
    if (Rst_n) begin
      case (state)
        S_FLUSH: begin
          fifo_EN   = 1'b1;
          state_nxt = S_RUN;
        end
        default: begin
          fifo_EN  = 1'b1;
          fifo_Rst = 1'b0;
          if (Flush)                              state_nxt = S_FLUSH;
          else if (wr_ok && (!rd_ok || !phase))   do_wr     = 1'b1;
          else if (rd_ok)                         do_rd     = 1'b1;
          if (do_wr) begin
            req_ready   = gnt;
            fifo_WR     = 1'b1;
            fifo_dataIn = wr_data;
          end
          fifo_RD = do_rd;
        end
      endcase
    end
  end

  // Occupancy, arbitration history, read pipeline and flag cross-check.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count       <= '0;
      last        <= IW'(NREQ - 1);
      phase       <= 1'b0;
      rd_inflight <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      err         <= 1'b0;
      first_run   <= 1'b0;
    end else begin
      first_run <= (state == S_FLUSH);
      if (state == S_FLUSH) begin
        count       <= '0;
        rd_inflight <= 1'b0;
        out_valid   <= 1'b0;
      end else begin
        if (do_wr) begin
          last  <= gnt_idx;
          count <= count + CW'(1);
          phase <= 1'b1;
        end else if (do_rd) begin
          count       <= count - CW'(1);
          rd_inflight <= 1'b1;
          phase       <= 1'b0;
        end
        // A read still in flight when Flush arrives is dropped.
        if (rd_inflight) begin
          rd_inflight <= 1'b0;
          if (!Flush) begin
            out_data  <= fifo_dataOut;
            out_valid <= 1'b1;
          end
        end else if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
        if (!first_run &&
            ((fifo_FULL != (count == CW'(DEPTH))) || (fifo_EMPTY != (count == '0))))
          err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_controller.sv
// Bench for fifo_rr_controller with a behavioural 8x4 FIFO attached and a
// scoreboard monitor that checks popped words and read-to-valid latency.
module tb_fifo_rr_controller;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned DW    = 4;
  localparam int unsigned DEPTH = 8;
  localparam int OP_IDLE = -1;
  localparam int OP_READ = -2;

  logic               Clk = 1'b0;
  logic               Rst_n = 1'b0;
  logic               Flush = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               out_valid, out_ready = 1'b0;
  logic [DW-1:0]      out_data;
  logic               fifo_EN, fifo_WR, fifo_RD, fifo_Rst;
  logic [DW-1:0]      fifo_dataIn, fifo_dataOut;
  logic               fifo_FULL, fifo_EMPTY;
  logic               busy, err;

  logic [DW-1:0] rdata [NREQ];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sb[$];
  int rdq[$];

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  always_comb
    for (int i = 0; i < int'(NREQ); i++) req_data[i*DW +: DW] = rdata[i];

  fifo_rr_controller #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .fifo_EN(fifo_EN), .fifo_WR(fifo_WR), .fifo_RD(fifo_RD), .fifo_Rst(fifo_Rst),
    .fifo_dataIn(fifo_dataIn), .fifo_dataOut(fifo_dataOut),
    .fifo_FULL(fifo_FULL), .fifo_EMPTY(fifo_EMPTY),
    .busy(busy), .err(err)
  );

  // Behavioural FIFObuffer: synchronous reset, registered read data.
  logic [DW-1:0] fmem [DEPTH];
  int            fcnt = 0;
  logic [2:0]    wp = '0, rp = '0;
  logic [DW-1:0] fdout = '0;
  logic          force_ne = 1'b0;

  assign fifo_dataOut = fdout;
  assign fifo_FULL    = (fcnt == int'(DEPTH));
  assign fifo_EMPTY   = (fcnt == 0) && !force_ne;

  always @(posedge Clk) begin
    if (fifo_EN) begin
      if (fifo_Rst) begin
        fcnt <= 0; wp <= '0; rp <= '0; fdout <= '0;
      end else begin
        if (fifo_WR && fcnt < int'(DEPTH)) begin fmem[wp] <= fifo_dataIn; wp <= wp + 3'd1; end
        if (fifo_RD && fcnt > 0)           begin fdout <= fmem[rp]; rp <= rp + 3'd1; end
        fcnt <= fcnt + ((fifo_WR && fcnt < int'(DEPTH)) ? 1 : 0) - ((fifo_RD && fcnt > 0) ? 1 : 0);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: read-to-valid latency and scoreboard compare on each handshake.
  logic pv = 1'b0, phs = 1'b0;
  always @(negedge Clk) begin
    if (!Rst_n) begin
      pv = 1'b0; phs = 1'b0;
    end else begin
      if (fifo_RD) rdq.push_back(cyc + 2);
      if (out_valid && (!pv || phs)) begin
        if (rdq.size() == 0) check("rd_latency_orphan", rdq.size(), 1);
        else                 check("rd_to_valid_cycle", cyc, rdq.pop_front());
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("sb_unexpected_word", sb.size(), 1);
        else                check("sb_out_data", int'(out_data), sb.pop_front());
      end
      pv  = out_valid;
      phs = out_valid && out_ready;
    end
  end

  // One cycle: drive, sample at negedge against the expected op, push writes.
  task automatic step(input logic [NREQ-1:0] rv, input logic ordy, input int op, input string tag);
    req_valid = rv;
    out_ready = ordy;
    @(negedge Clk);
    check({tag, "_wr"}, int'(fifo_WR), (op >= 0) ? 1 : 0);
    check({tag, "_rd"}, int'(fifo_RD), (op == OP_READ) ? 1 : 0);
    check({tag, "_gnt"}, int'(req_ready), (op >= 0) ? (1 << op) : 0);
    check({tag, "_excl"}, int'(fifo_WR && fifo_RD), 0);
    if (op >= 0) begin
      check({tag, "_din"}, int'(fifo_dataIn), int'(rdata[op]));
      sb.push_back(int'(rdata[op]));
    end
    @(posedge Clk); #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    req_valid = '0;
    out_ready = 1'b1;
    while ((busy || sb.size() != 0) && n < 80) begin
      @(negedge Clk);
      check({tag, "_drain_excl"}, int'(fifo_WR && fifo_RD), 0);
      @(posedge Clk); #1;
      n++;
    end
    check({tag, "_drain_in_time"}, int'(n < 80), 1);
    check({tag, "_sb_empty"}, sb.size(), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_empty_flag"}, int'(fifo_EMPTY), 1);
    check({tag, "_err"}, int'(err), 0);
  endtask

  int rr_ops [11] = '{0, OP_READ, 1, 2, 3, 0, 1, 2, 3, 0, OP_IDLE};
  int ct_ops [8]  = '{2, OP_READ, 2, 2, OP_READ, 2, 2, OP_READ};

  initial begin
    int nw;
    rdata[0] = 4'd1; rdata[1] = 4'd2; rdata[2] = 4'd3; rdata[3] = 4'd4;

    // Reset values
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_fifo_Rst", int'(fifo_Rst), 1);
    check("rst_fifo_EN", int'(fifo_EN), 0);
    check("rst_fifo_WR", int'(fifo_WR), 0);
    check("rst_fifo_RD", int'(fifo_RD), 0);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_dataIn", int'(fifo_dataIn), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);

    // Release: one flush cycle then run
    @(posedge Clk); #1; Rst_n = 1'b1;
    @(negedge Clk);
    check("flush_cyc_Rst", int'(fifo_Rst), 1);
    check("flush_cyc_EN", int'(fifo_EN), 1);
    @(posedge Clk); #1;
    @(negedge Clk);
    check("run_Rst", int'(fifo_Rst), 0);
    check("run_EN", int'(fifo_EN), 1);
    check("run_busy", int'(busy), 0);
    check("run_err", int'(err), 0);
    @(posedge Clk); #1;

    // Round-robin fill with the output stalled; one read slips in after the first write
    foreach (rr_ops[k]) step(4'b1111, 1'b0, rr_ops[k], "rr");
    check("rr_full_flag", int'(fifo_FULL), 1);
    check("rr_out_valid_held", int'(out_valid), 1);
    drain("rr");

    // Contention: requester 2 only, consumer always ready
    rdata[2] = 4'h9;
    foreach (ct_ops[k]) step(4'b0100, 1'b1, ct_ops[k], "ct");
    drain("ct");

    // Back-pressure: held word, no reads until the consumer takes it
    rdata[1] = 4'h5;
    step(4'b0010, 1'b0, 1, "bp_w0");
    step(4'b0010, 1'b0, OP_READ, "bp_r0");
    rdata[1] = 4'h6;
    step(4'b0010, 1'b0, 1, "bp_w1");
    for (int k = 0; k < 3; k++) begin
      step(4'b0000, 1'b0, OP_IDLE, "bp_hold");
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_data", int'(out_data), 5);
    end
    step(4'b0000, 1'b1, OP_IDLE, "bp_accept");
    step(4'b0000, 1'b1, OP_READ, "bp_next_rd");
    drain("bp");

    // Flush with 5 words stored and one held at the output
    rdata[0] = 4'hA;
    nw = 0;
    for (int k = 0; k < 30 && nw < 6; k++) begin
      req_valid = 4'b0001;
      out_ready = 1'b0;
      @(negedge Clk);
      if (fifo_WR) begin
        check("fl_din", int'(fifo_dataIn), 10);
        check("fl_gnt", int'(req_ready), 1);
        sb.push_back(10);
        nw++;
      end
      @(posedge Clk); #1;
    end
    check("fl_writes", nw, 6);
    check("fl_stored", fcnt, 5);
    Flush = 1'b1;
    @(negedge Clk);
    check("fl_req_wr", int'(fifo_WR), 0);
    check("fl_req_rd", int'(fifo_RD), 0);
    check("fl_req_gnt", int'(req_ready), 0);
    @(posedge Clk); #1;
    Flush = 1'b0;
    req_valid = '0;
    @(negedge Clk);
    check("fl_state_Rst", int'(fifo_Rst), 1);
    check("fl_state_EN", int'(fifo_EN), 1);
    check("fl_state_gnt", int'(req_ready), 0);
    @(posedge Clk); #1;
    @(negedge Clk);
    check("fl_out_valid", int'(out_valid), 0);
    check("fl_busy", int'(busy), 0);
    check("fl_err", int'(err), 0);
    check("fl_fifo_empty", int'(fifo_EMPTY), 1);
    sb.delete();
    rdq.delete();
    @(posedge Clk); #1;

    // Flag mismatch: EMPTY low while the controller's count is zero
    force_ne = 1'b1;
    @(negedge Clk);
    check("err_before", int'(err), 0);
    @(posedge Clk); #1;
    force_ne = 1'b0;
    @(negedge Clk);
    check("err_set", int'(err), 1);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("err_sticky", int'(err), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
